digit_entry: RTL
================

// Module: digit_entry
// PURPOSE
//  Parametrised answer-entry block for the factorisation quiz. Holds NUM_DIGITS BCD digit counters, each stepped by its own button, and latches the answer on DEC.
//  Latches the question digits for display and reports question-present (QUE_OK/LED).
//  Sits between the button/switch front end (debounced, synchronous to CLK) and the game FSM / 7-seg drivers.
//  Successor features: N digits, up/down stepping, edge-triggered presses, one-cycle ANS_VALID strobe, async reset.
// PARAMETERS
//  NUM_DIGITS  3  number of answer/question digits (1..8)
//  DIGIT_MAX   9  highest digit value; must be 1..15
//  WRAP_MIN    1  value loaded when incrementing past DIGIT_MAX, and the value at which decrement wraps to DIGIT_MAX
// PORTS
//  CLK          in   1       system clock
//  RST          in   1       asynchronous, active-high reset
//  STATE        in   4       game FSM state code (codes in package)
//  SEL          in   N       per-digit step buttons, bit i -> digit i (digit 0 = least significant)
//  DOWN         in   1       1: presses decrement, 0: presses increment
//  CLR          in   1       clear all digits (INPUT state only)
//  DEC          in   1       decide: commit the answer
//  QUESTION     in   8N      upper 4N bits = question digits, lower 4N bits ignored
//  SEG          out  4N      live entry digits for display
//  SEG_Q        out  4N      question digits for display
//  ANSWER       out  4N      committed answer
//  ANS_VALID    out  1       one-cycle strobe when ANSWER is updated
//  QUE_OK       out  1       latched question is nonzero
//  LED          out  1       QUE_OK delayed by one cycle
// BEHAVIOUR
//  Reset: one clock and one reset; reset is asynchronous and active-high. On RST, every register and output is 0, including the edge-detect history.
//  Press detection: sel_d <= SEL, clr_d <= CLR, dec_d <= DEC. press = SEL & ~sel_d, likewise for CLR and DEC. A held button acts once.
//  Digit update: takes effect only in ST_INPUT, at the clock edge where the press is seen.
//   - Lowest-index pressed bit wins; other bits pressed in the same cycle are dropped.
//   - Increment: d==DIGIT_MAX -> WRAP_MIN, else d+1.
//   - Decrement: d<=WRAP_MIN -> DIGIT_MAX, else d-1. A digit at 0 (initial value) decrements to DIGIT_MAX.
//   - Priority in ST_INPUT: SEL press > CLR press. CLR sets all digits to 0.
//  Clear states: in ST_CHECK, ST_CORRECT, ST_END0, ST_END1 or ST_END2, all digits are forced to 0 every cycle.
//  All other states: digits hold.
//  SEG: registered. Equals the digits in ST_INPUT, else 0. A press appears on SEG one cycle after the digit update.
//  Question latch q_r (4N bits): loads QUESTION[8N-1:4N] when any of these holds, else loads 0:
//   - ST_READY and QUESTION != 0
//   - ST_QUESTION
//   - ST_INPUT
//   - ST_WRONG
//  QUE_OK <= (q_r != 0). LED <= QUE_OK. Total latency QUESTION -> LED is 3 cycles.
//  SEG_Q: registered. Equals q_r in ST_QUESTION, else 0.
//  Commit: a DEC press in ST_INPUT loads ANSWER from the current digits (pre-update value if SEL is pressed in the same cycle) and sets ANS_VALID=1 for exactly one cycle. ANSWER holds otherwise, across all states.
//  DEC or CLR presses outside ST_INPUT are ignored, but their edge history still updates.
//  Unknown STATE codes: digits hold, and SEG, SEG_Q and q_r go to 0.
//  RST mid-entry: everything returns to 0 immediately. The first CLK edge after release only samples history, so no press is registered on a button still held.
// STRUCTURE
//  Package digit_entry_pkg: 4-bit state codes
//   ST_READY=4'b0010, ST_QUESTION=4'b0011, ST_INPUT=4'b0100, ST_CHECK=4'b0110,
//   ST_WRONG=4'b0111, ST_CORRECT=4'b1000, ST_END0=4'b1001, ST_END1=4'b1010, ST_END2=4'b1011;
//   DIGIT_W=4.
//  Sub-module digit_counter (inputs: inc, dec, clr, force0; output: 4-bit value). Instantiated NUM_DIGITS times via generate.
//  Top level holds edge detection, the priority encoder, the question path and the commit logic.
// TESTING (NUM_DIGITS=3, DIGIT_MAX=9, WRAP_MIN=1)
//  1. STATE=INPUT; pulse SEL[0] 10 times with DOWN=0 -> digit0 goes 1..9 then 1. SEL[0] held 20 cycles -> digit0 steps once.
//  2. DOWN=1; from 0, press SEL[2] -> 9; press again -> 8. SEL=3'b011 in the same cycle -> only digit0 changes.
//  3. Digits=3,5,7 (d2..d0); DEC press -> ANSWER=12'h357 and ANS_VALID high 1 cycle. Hold DEC -> no second strobe. STATE=CHECK -> SEG=0 and digits=0, ANSWER stays 12'h357.
//  4. STATE=READY with QUESTION=24'h123000 -> QUE_OK=1 two cycles later, LED=1 three cycles later. STATE=QUESTION -> SEG_Q=12'h123. STATE=READY with QUESTION=0 -> QUE_OK falls.
//  5. CLR and SEL[1] pressed together in INPUT -> SEL wins. CLR alone -> all digits 0. CLR in STATE=QUESTION -> no effect.
//  6. Assert RST mid-entry with digits=12'h482 and SEL held -> all outputs 0 asynchronously. After release, no increment occurs until SEL is released and pressed again.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared definitions for the quiz answer-entry block.
// Contents: game FSM state codes, BCD digit width and state-decoding helpers.
// No ports; imported by digit_entry and digit_counter.
package digit_entry_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [3:0] {
        ST_READY    = 4'b0010,
        ST_QUESTION = 4'b0011,
        ST_INPUT    = 4'b0100,
        ST_CHECK    = 4'b0110,
        ST_WRONG    = 4'b0111,
        ST_CORRECT  = 4'b1000,
        ST_END0     = 4'b1001,
        ST_END1     = 4'b1010,
        ST_END2     = 4'b1011
    } state_e;

    // States in which the entry digits are wiped every cycle.
    function automatic logic is_clear_state(input logic [3:0] s);
        logic r;
        r = 1'b0;
        case (s)
            ST_CHECK, ST_CORRECT, ST_END0, ST_END1, ST_END2: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

    // States in which the question latch follows the question bus.
    function automatic logic loads_question(input logic [3:0] s, input logic q_nonzero);
        logic r;
        r = 1'b0;
        case (s)
            ST_READY:                        r = q_nonzero;
            ST_QUESTION, ST_INPUT, ST_WRONG: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/digit_counter.sv
// One BCD-style entry digit with wrap-around stepping in both directions.
// Ports: clk_i/rst_i; inc_i/dec_i step requests; clr_i/force0_i zero the digit; value_o digit.
// Zeroing beats stepping; inc_i beats dec_i (the top never raises both).
module digit_counter
    import digit_entry_pkg::*;
#(
    parameter int DIGIT_MAX = 9,
    parameter int WRAP_MIN  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               clr_i,
    input  logic               force0_i,
    output logic [DIGIT_W-1:0] value_o
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(DIGIT_MAX);
    localparam logic [DIGIT_W-1:0] MIN_V = DIGIT_W'(WRAP_MIN);
    localparam logic [DIGIT_W-1:0] ONE_V = DIGIT_W'(1);

    logic [DIGIT_W-1:0] value_q;
    logic [DIGIT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (force0_i || clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = (value_q == MAX_V) ? MIN_V : value_q + ONE_V;
        end else if (dec_i) begin
            // '<=' so the power-up value 0 also wraps to the top.
            value_d = (value_q <= MIN_V) ? MAX_V : value_q - ONE_V;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/digit_entry.sv
// Answer entry for the factorisation quiz: N stepped digits, answer commit, question latch.
// Ports: clk_i/rst_i; state_i game state; sel_i/down_i/clr_i/dec_i buttons; question_i;
//        seg_o/seg_q_o display, answer_o/ans_valid_o commit, que_ok_o/led_o question-present.
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int DIGIT_MAX  = 9,
    parameter int WRAP_MIN   = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [3:0]                        state_i,
    input  logic [NUM_DIGITS-1:0]             sel_i,
    input  logic                              down_i,
    input  logic                              clr_i,
    input  logic                              dec_i,
    input  logic [2*NUM_DIGITS*DIGIT_W-1:0]   question_i,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     seg_o,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     seg_q_o,
    output logic [NUM_DIGITS*DIGIT_W-1:0]     answer_o,
    output logic                              ans_valid_o,
    output logic                              que_ok_o,
    output logic                              led_o
);

    localparam int W = NUM_DIGITS * DIGIT_W;
    localparam logic [NUM_DIGITS-1:0] ONE_N = NUM_DIGITS'(1);

    // Button history. hist_vld_q stays low for the first edge after reset so
    // a button already held at release is recorded but not taken as a press.
    logic [NUM_DIGITS-1:0] sel_q;
    logic                  clr_q, dec_q, hist_vld_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q      <= '0;
            clr_q      <= 1'b0;
            dec_q      <= 1'b0;
            hist_vld_q <= 1'b0;
        end else begin
            sel_q      <= sel_i;
            clr_q      <= clr_i;
            dec_q      <= dec_i;
            hist_vld_q <= 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] sel_press, sel_first, digit_inc, digit_dec;
    logic                  clr_press, dec_press, in_input, force0, clr_all, commit;

    assign sel_press = hist_vld_q ? (sel_i & ~sel_q) : '0;
    assign clr_press = hist_vld_q & clr_i & ~clr_q;
    assign dec_press = hist_vld_q & dec_i & ~dec_q;

    // Isolate the lowest set bit: the lowest-index press wins.
    assign sel_first = sel_press & (~sel_press + ONE_N);

    assign in_input  = (state_i == ST_INPUT);
    assign force0    = is_clear_state(state_i);
    assign clr_all   = in_input & clr_press & ~(|sel_press);
    assign digit_inc = sel_first & {NUM_DIGITS{in_input & ~down_i}};
    assign digit_dec = sel_first & {NUM_DIGITS{in_input &  down_i}};
    assign commit    = in_input & dec_press;

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        digit_counter #(
            .DIGIT_MAX (DIGIT_MAX),
            .WRAP_MIN  (WRAP_MIN)
        ) u_digit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .inc_i    (digit_inc[i]),
            .dec_i    (digit_dec[i]),
            .clr_i    (clr_all),
            .force0_i (force0),
            .value_o  (digits[i])
        );
    end

    // Display, question and commit registers.
    logic [W-1:0] seg_q, seg_d;
    logic [W-1:0] question_q, question_d;
    logic [W-1:0] segq_q, segq_d;
    logic [W-1:0] answer_q, answer_d;
    logic         ans_valid_q, que_ok_q, led_q;
    logic [W-1:0] question_hi;
    logic         unused_question_lo;

    assign question_hi        = question_i[2*W-1:W];
    assign unused_question_lo = ^question_i[W-1:0];

    always_comb begin
        seg_d      = in_input ? digits : '0;
        question_d = loads_question(state_i, |question_hi) ? question_hi : '0;
        // Shows the latch contents, so lags the question bus by one cycle.
        segq_d     = (state_i == ST_QUESTION) ? question_q : '0;
        // Commit captures the digits as they stand before this edge's step.
        answer_d   = commit ? digits : answer_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_q       <= '0;
            question_q  <= '0;
            segq_q      <= '0;
            answer_q    <= '0;
            ans_valid_q <= 1'b0;
            que_ok_q    <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            question_q  <= question_d;
            segq_q      <= segq_d;
            answer_q    <= answer_d;
            ans_valid_q <= commit;
            que_ok_q    <= |question_q;
            led_q       <= que_ok_q;
        end
    end

    assign seg_o       = seg_q;
    assign seg_q_o     = segq_q;
    assign answer_o    = answer_q;
    assign ans_valid_o = ans_valid_q;
    assign que_ok_o    = que_ok_q;
    assign led_o       = led_q;

endmodule
